// File: rtl/fetch_unit_sv_pkg.sv
// rtl/fetch_unit_sv_pkg.sv - shared fetch types and constants for the IF front end
package fetch_unit_sv_pkg;

    localparam int IMEM_WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Maps straight onto the IF/ID stage register in main_sv.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_t;

endpackage

// File: rtl/fetch_fifo_sv.sv
// rtl/fetch_fifo_sv.sv - synchronous FIFO with flush, used for the instruction buffer and pc queue
module fetch_fifo_sv #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit_sv.sv
// rtl/fetch_unit_sv.sv - instruction fetch front end; define FETCH_PERF_CNT_EN for perf counters
module fetch_unit_sv
    import fetch_unit_sv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  id_ready,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_dropped
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(IMEM_WORD_BYTES - 1);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic [CNT_W:0]        credit;
    logic                  req_valid, req_fire;
    logic                  rsp_fire, rsp_keep, rsp_drop, if_pop;

    logic [ENTRY_W-1:0]    ibuf_head;
    logic [CNT_W-1:0]      ibuf_count;
    logic                  ibuf_full, ibuf_empty;
    logic [ADDR_WIDTH-1:0] pcq_head;
    logic [CNT_W-1:0]      pcq_count;
    logic                  pcq_full, pcq_empty;
    logic                  unused_ok;

    // Buffered plus in-flight words never exceed the buffer, so every response has a home.
    always_comb begin
        credit    = {1'b0, ibuf_count} + {1'b0, outstanding_q};
        req_valid = !reset && !redirect_valid && !pcq_full
                    && (credit < (CNT_W + 1)'(FIFO_DEPTH));
        req_fire  = req_valid && imem_req_ready;
        rsp_fire  = imem_rsp_valid && (outstanding_q != '0);
        rsp_drop  = rsp_fire && (drop_cnt_q != '0);
        rsp_keep  = rsp_fire && (drop_cnt_q == '0) && !pcq_empty;
        if_pop    = !ibuf_empty && id_ready;

        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);

        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & WORD_MASK;
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt_d = outstanding_q - CNT_W'(rsp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(IMEM_WORD_BYTES);
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo_sv #(.WIDTH(ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_pc_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (rsp_keep),
        .flush     (redirect_valid),
        .head      (pcq_head),
        .count     (pcq_count),
        .full      (pcq_full),
        .empty     (pcq_empty)
    );

    fetch_fifo_sv #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_instr_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_keep),
        .push_data ({pcq_head, imem_rsp_data}),
        .pop       (if_pop),
        .flush     (redirect_valid),
        .head      (ibuf_head),
        .count     (ibuf_count),
        .full      (ibuf_full),
        .empty     (ibuf_empty)
    );

    assign unused_ok = &{1'b0, ibuf_full, pcq_count};

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign if_valid       = !ibuf_empty;
    assign if_pc          = ibuf_head[ENTRY_W-1:DATA_WIDTH];
    assign if_instr       = ibuf_head[DATA_WIDTH-1:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_dropped_q, perf_dropped_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(if_pop);
        perf_dropped_d = perf_dropped_q + 32'(rsp_drop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_dropped_q <= perf_dropped_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`else
    assign perf_fetched = '0;
    assign perf_dropped = '0;
`endif

endmodule

// File: doc/fetch_unit_sv.md
Name: fetch_unit_sv

Overview:
Instruction-fetch front end that sits directly upstream of the IF/ID boundary in main_sv. Drives the PC and issues in-order requests to instruction memory over a valid/ready handshake with variable response latency. Buffers returned words in a small FIFO and presents {pc, instr} to the decode stage. Supports stall from decode and redirect (branch/jump flush) from EX, discarding stale in-flight responses.

Parameters:
ADDR_WIDTH, 32, PC/address width in bits
DATA_WIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 4, instruction buffer entries and maximum outstanding requests (power of 2, ≥2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  imem accepts request this cycle
imem_req_addr  output  ADDR_WIDTH  fetch address (word aligned)
imem_rsp_valid  input  1  response data valid (in request order, ≥1 cycle after accept)
imem_rsp_data  input  DATA_WIDTH  returned instruction
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  ADDR_WIDTH  new fetch PC (bits [1:0] ignored, treated as 0)
id_ready  input  1  decode consumes the presented instruction (deasserted = stall)
if_valid  output  1  if_pc/if_instr valid
if_pc  output  ADDR_WIDTH  PC of presented instruction
if_instr  output  DATA_WIDTH  presented instruction
perf_fetched  output  32  instructions delivered to decode (optional feature)
perf_dropped  output  32  responses discarded after redirect (optional feature)

Behaviour:
- Reset (async assert, release sync to clk): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0; imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, perf counters=0. Reset mid-transaction abandons all in-flight requests; responses arriving after release with outstanding=0 are ignored.
- Issue: imem_req_valid=1 when (fifo_count + outstanding) < FIFO_DEPTH and redirect_valid=0. Accept = valid&&ready: outstanding+1, fetch_pc+=4 (wraps modulo 2^ADDR_WIDTH). imem_req_addr held stable while valid && !ready.
- Pending-PC queue: each accepted address pushed to a FIFO_DEPTH-deep pc queue; popped on each response.
- Response: on imem_rsp_valid, outstanding-1; if drop_cnt>0, drop_cnt-1 and discard; else push {pc, data} to instruction FIFO. Credit rule guarantees no overflow; response with outstanding=0 ignored (no underflow).
- Decode side: if_valid = FIFO non-empty; if_pc/if_instr = FIFO head (0 when empty). Pop on if_valid && id_ready. Minimum latency: request accept at cycle N, response at N+1, visible at if_valid in N+2.
- Simultaneous push and pop on a full or empty FIFO permitted; count unchanged on a full FIFO; on empty, the pushed entry appears next cycle (no bypass).
- Redirect (highest priority): same cycle, FIFO flushed, pc queue cleared, fetch_pc=redirect_pc, drop_cnt=outstanding minus any response discarded this cycle, no request issued. Accept in the same cycle is impossible (valid forced 0). Next cycle issues from redirect_pc. A redirect while drop_cnt>0 reloads drop_cnt per the same rule.
- Back-to-back redirects: last one wins; if_valid stays 0 until a post-redirect response arrives.

Optional Feature:
FETCH_PERF_CNT_EN defined: perf_fetched increments on every decode pop, perf_dropped on every discarded response; both 32-bit wrapping, cleared by reset. Not defined: counter logic absent, both ports tied to 0.

Decomposition:
- struct_pkg: fetch_entry_t {pc, instr}, IMEM_WORD_BYTES=4 constant, and an extension of if_t carrying valid/pc/instr so main_sv maps fetch output directly to if_stage_out.
- Sub-module fetch_fifo_sv: parameterised synchronous FIFO (WIDTH, DEPTH) with push/pop/flush/count/full/empty; instanced for the instruction buffer and the pc queue.

Test Plan:
- Reset, imem_req_ready=1, 1-cycle rsp latency, id_ready=1 -> first req addr 0x0, if_valid at cycle 3 with if_pc=0x0, then pcs 0x4, 0x8, … one per cycle.
- id_ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 requests outstanding+buffered, imem_req_valid drops; release -> pcs 0x0..0xC delivered in order, no loss or duplication.
- imem_req_ready toggled 0/1 randomly -> imem_req_addr stable while stalled; delivered pc sequence strictly +4.
- 3 requests outstanding (latency 4), redirect_pc=0x100 -> next 3 responses discarded (perf_dropped=3 with FETCH_PERF_CNT_EN), first if_pc=0x100.
- fetch_pc=0xFFFF_FFFC -> next request addr 0x0000_0000 (wrap).
- reset asserted mid-stream with responses pending -> outputs return to reset values immediately; post-release fetch restarts at RESET_PC, stale responses ignored.
